gray_seq_ctrl: RTL and testbench
================================

# gray_seq_ctrl

Sequencer that drives a binary step counter and its Gray-code image through controlled sweeps. It sits between the control logic (start/stop/mode) and any consumer of a stepping Gray-coded position: encoder emulation, LED/stepper phase drive, or CDC pointer tests. It provides single-sweep and continuous modes, a step prescaler, busy/step/done status, and optional reverse direction.

## Interface
- WIDTH, 4, code width in bits; must be ≥ 2.
- STEP_DIV, 1, clock cycles per step; must be ≥ 1.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; sampled in IDLE and starts a sweep.
- stop  in  1  level; aborts a running sweep.
- mode  in  1  0 = single sweep, 1 = continuous wrap; latched at start.
- dir  in  1  0 = up, 1 = down; latched at start. Used only with the macro (see Configuration).
- busy  out  1  high while in RUN.
- bin  out  WIDTH  current binary count, registered.
- gray  out  WIDTH  registered bin ^ (bin >> 1); always consistent with bin in the same cycle.
- step  out  1  one-cycle pulse in the cycle bin/gray take a new stepped value.
- done  out  1  one-cycle pulse when a single sweep completes.

## Operation
- Reset: state IDLE, bin=0, gray=0, busy=0, step=0, done=0, prescaler=0, latched mode/dir=0.
- FSM states are IDLE and RUN. DONE is a one-cycle output pulse, not a separate state.
- IDLE with start=1 and stop=0:
  - latch mode and dir;
  - load bin to 0 (up) or 2^WIDTH−1 (down), with gray to match;
  - clear the prescaler; busy=1; enter RUN;
  - the load itself does not pulse step.
- IDLE with start=1 and stop=1: stop wins; stay in IDLE with no change.
- RUN prescaler counts 0..STEP_DIV−1. When it equals STEP_DIV−1 it wraps to 0 and a step event occurs.
- Step event, normal case: bin ← bin±1 (mod 2^WIDTH), gray updated on the same edge, step=1 for that cycle.
- Step event at the terminal value (2^WIDTH−1 up, 0 down):
  - Continuous mode: wrap (15→0 or 0→15 for WIDTH=4) with a normal step pulse.
  - Single mode: no count change and no step pulse; done=1 for one cycle, busy=0, return to IDLE. bin/gray hold the terminal value.
- stop=1 in RUN: return to IDLE on the next edge.
  - bin/gray hold; busy=0; no done; prescaler cleared.
  - stop takes priority over a coincident step or terminal event.
- start in RUN is ignored. Changes to mode/dir during RUN are ignored.
- Outputs hold indefinitely in IDLE. A new start reloads the start value.
- rst in any state, including mid-sweep, forces the reset values on the next edge. Reset overrides start and stop.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Let E0 be the edge that samples start. After E0: busy=1 and bin = start value.
- Step k (k ≥ 1) lands at edge E(k·STEP_DIV).
- Single up sweep: bin=k after E(k·STEP_DIV) for k=1..2^WIDTH−1. done=1 and busy=0 after E(2^WIDTH·STEP_DIV).
- Exactly 2^WIDTH−1 step pulses per single sweep.
- Consecutive gray values differ in exactly one bit, including across the continuous wrap.
- The earliest new start is the cycle after done. It is sampled at the next edge.

## Configuration
- Macro GRAY_SEQ_DIR_EN.
- Defined: dir is latched at start and selects up or down counting, down start value, and down terminal/wrap.
- Undefined: the dir port exists but is ignored. The latched direction is constant up, and the down-count logic is not synthesized.

## Test plan
- Reset then start (mode=0, STEP_DIV=1, WIDTH=4):
  - gray sequence 0000,0001,0011,0010,0110,…,1000 on consecutive cycles;
  - 15 step pulses;
  - done at E16 with gray=1000, busy=0.
- Continuous, STEP_DIV=3:
  - step every 3 cycles;
  - bin 15→0 wrap gives gray 1000→0000 with step=1;
  - busy stays high across the wrap and no done is asserted.
- Stop at bin=6 (gray=0101) coinciding with a step edge:
  - bin holds 6; no step, no done; busy=0 on the next cycle;
  - a following start reloads bin=0.
- With GRAY_SEQ_DIR_EN, dir=1 single sweep:
  - starts at bin=15/gray=1000 and counts down to 0;
  - done after 16 steps-worth of cycles.
  - Same stimulus without the macro: up sweep.
- start=stop=1 in IDLE → no state change.
- rst asserted mid-sweep at bin=9 → all outputs 0 next cycle and IDLE.
- start during RUN → no reload, sequence continues.

Source files
------------

// File: rtl/gray_seq_ctrl.sv
// Gray-coded step sequencer: single/continuous sweeps with prescaler; GRAY_SEQ_DIR_EN enables down counting.
// Outputs registered, no input-to-output path; no backpressure, stop aborts a sweep on the next edge.
module gray_seq_ctrl #(
  parameter int WIDTH    = 4,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             dir,
  output logic             busy,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             step,
  output logic             done
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    presc, presc_n;
  logic [WIDTH-1:0] bin_n;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] bin_adv;
  logic             at_term;
  logic             mode_q, mode_n;
  logic             step_n, done_n;
  logic             load;

`ifdef GRAY_SEQ_DIR_EN
  logic dir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= 1'b0;
    end else if (load) begin
      dir_q <= dir;
    end
  end

  // The start value follows the live dir input because it is latched on the same edge.
  always_comb begin
    start_val = {WIDTH{dir}};
    at_term   = dir_q ? (bin == '0) : (&bin);
    bin_adv   = dir_q ? (bin - WIDTH'(1)) : (bin + WIDTH'(1));
  end
`else
  logic unused_dir;
  assign unused_dir = dir;

  always_comb begin
    start_val = '0;
    at_term   = &bin;
    bin_adv   = bin + WIDTH'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bin    <= '0;
      gray   <= '0;
      presc  <= '0;
      step   <= 1'b0;
      done   <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      state  <= state_n;
      bin    <= bin_n;
      gray   <= bin_n ^ (bin_n >> 1);
      presc  <= presc_n;
      step   <= step_n;
      done   <= done_n;
      mode_q <= mode_n;
    end
  end

  always_comb begin
    state_n = state;
    bin_n   = bin;
    presc_n = presc;
    mode_n  = mode_q;
    step_n  = 1'b0;
    done_n  = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          load    = 1'b1;
          mode_n  = mode;
          bin_n   = start_val;
          presc_n = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        // stop outranks any step or terminal event landing on the same edge
        if (stop) begin
          presc_n = '0;
          state_n = IDLE;
        end else if (presc == PRESC_LAST) begin
          presc_n = '0;
          if (at_term && !mode_q) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            bin_n  = bin_adv;
            step_n = 1'b1;
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Scoreboard bench for gray_seq_ctrl (WIDTH=4, STEP_DIV=3); step/done events are checked against queued expectations.
module tb_gray_seq_ctrl;

  localparam int W  = 4;
  localparam int SD = 3;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         stop  = 1'b0;
  logic         mode  = 1'b0;
  logic         dir   = 1'b0;
  logic         busy, step, done;
  logic [W-1:0] bin, gray;

  int unsigned ecnt  = 0;
  int          total = 0;
  int          bad   = 0;

  logic [3:0] gtbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  typedef struct {
    int unsigned at;
    bit          is_done;
    logic [3:0]  b;
    logic [3:0]  g;
  } ev_t;

  ev_t exp_q[$];
  ev_t cur;

  gray_seq_ctrl #(.WIDTH(W), .STEP_DIV(SD)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .dir(dir),
    .busy(busy), .bin(bin), .gray(gray), .step(step), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, expv, ecnt);
    end
  endtask

  // event word: edge[15:0], step, done, busy, 0, bin, gray
  always @(negedge clk) begin
    if (step || done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got step=%0d done=%0d bin=%0d at edge %0d expected no event",
                 step, done, bin, ecnt);
      end else begin
        cur = exp_q.pop_front();
        chk("event", {4'h0, ecnt[15:0], step, done, busy, 1'b0, bin, gray},
            {4'h0, cur.at[15:0], !cur.is_done, cur.is_done, !cur.is_done, 1'b0, cur.b, cur.g});
      end
    end
  end

  task automatic push_run(input int unsigned e0, input int first_k, input int last_k, input bit down);
    ev_t e;
    int  b;
    for (int k = first_k; k <= last_k; k++) begin
      b = down ? (15 - k) : (k % 16);
      e.at = e0 + k * SD;
      e.is_done = 1'b0;
      e.b = 4'(b);
      e.g = gtbl[b];
      exp_q.push_back(e);
    end
  endtask

  task automatic push_done(input int unsigned at, input int b);
    ev_t e;
    e.at = at;
    e.is_done = 1'b1;
    e.b = 4'(b);
    e.g = gtbl[b];
    exp_q.push_back(e);
  endtask

  task automatic wait_edge(input int unsigned n);
    while (ecnt < n) @(negedge clk);
  endtask

  // called at a negedge; returns at the negedge after the edge that sampled start
  task automatic do_start(input bit m, input bit d, input int sv, output int unsigned e0);
    start = 1'b1;
    mode  = m;
    dir   = d;
    @(negedge clk);
    start = 1'b0;
    e0 = ecnt;
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_bin",  32'(bin),  32'(sv));
    chk("load_gray", 32'(gray), 32'(gtbl[sv]));
    chk("load_step", 32'(step), 32'd0);
  endtask

  task automatic stop_at(input int unsigned n);
    wait_edge(n - 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    int unsigned e0;
    int          sv;
    bit          down;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bin",  32'(bin),  32'd0);
    chk("rst_gray", 32'(gray), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single up sweep: 15 steps then done holding 15 / 1000
    do_start(1'b0, 1'b0, 0, e0);
    push_run(e0, 1, 15, 1'b0);
    push_done(e0 + 16 * SD, 15);
    wait_edge(e0 + 16 * SD);
    repeat (4) @(negedge clk);
    chk("idle_hold_busy", 32'(busy), 32'd0);
    chk("idle_hold_bin",  32'(bin),  32'd15);
    chk("idle_hold_gray", 32'(gray), 32'h8);

    // start and stop together in IDLE: nothing happens
    start = 1'b1;
    stop  = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", 32'(busy), 32'd0);
    chk("startstop_bin",  32'(bin),  32'd15);

    // continuous: wrap 15->0 with a step, then stop on a step edge
    do_start(1'b1, 1'b0, 0, e0);
    push_run(e0, 1, 20, 1'b0);
    stop_at(e0 + 21 * SD);
    chk("cont_stop_busy", 32'(busy), 32'd0);
    chk("cont_stop_bin",  32'(bin),  32'd4);
    chk("cont_stop_gray", 32'(gray), 32'h6);

    // single sweep aborted at bin=6 on a step edge; mode change mid-run is ignored
    do_start(1'b0, 1'b0, 0, e0);
    mode = 1'b1;
    push_run(e0, 1, 6, 1'b0);
    stop_at(e0 + 7 * SD);
    chk("stop6_busy", 32'(busy), 32'd0);
    chk("stop6_step", 32'(step), 32'd0);
    chk("stop6_bin",  32'(bin),  32'd6);
    chk("stop6_gray", 32'(gray), 32'h5);
    repeat (5) @(negedge clk);
    chk("stop6_hold_bin", 32'(bin), 32'd6);

    // dir=1 sweep: down from 15 when the direction feature is built, up otherwise
`ifdef GRAY_SEQ_DIR_EN
    sv = 15;
    down = 1'b1;
`else
    sv = 0;
    down = 1'b0;
`endif
    do_start(1'b0, 1'b1, sv, e0);
    mode = 1'b1;
    dir  = 1'b0;
    push_run(e0, 1, 15, down);
    push_done(e0 + 16 * SD, down ? 0 : 15);
    wait_edge(e0 + 16 * SD);

    // back-to-back start right after done; a start during RUN must not reload
    do_start(1'b0, 1'b0, 0, e0);
    push_run(e0, 1, 9, 1'b0);
    wait_edge(e0 + 4 * SD + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // reset mid-sweep at bin=9
    wait_edge(e0 + 9 * SD);
    chk("pre_rst_bin", 32'(bin), 32'd9);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_bin",  32'(bin),  32'd0);
    chk("midrst_gray", 32'(gray), 32'd0);
    chk("midrst_step", 32'(step), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_bin",  32'(bin),  32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
